// File: rtl/seq_det_ctrl.sv
// Configurable serial pattern detector: up to 8-bit pattern, overlapping or
// non-overlapping matching, optional match-count target that ends a run.
//
// state | meaning
// IDLE  | config accepted, waiting for start
// RUN   | shifting serial bits, counting matches
// DONE  | one-cycle done pulse after target reached
module seq_det_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_pattern,
    input  logic [2:0] cfg_len,
    input  logic       cfg_overlap,
    input  logic [7:0] cfg_target,
    input  logic       start,
    input  logic       abort,
    input  logic       x,
    input  logic       x_valid,
    output logic       y,
    output logic       busy,
    output logic       done,
    output logic [7:0] match_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] pat_q;
    logic [2:0] len_q;
    logic       ovl_q;
    logic [7:0] tgt_q;
    logic       cfg_loaded;
    logic [6:0] hist;
    logic [3:0] fill;

    logic [7:0] window;
    logic [7:0] mask;
    logic       match;
    logic [7:0] cnt_inc;
    logic [3:0] fill_inc;

    // Newest bit sits in window[0]; only the low L bits take part in the compare.
    assign window   = {hist, x};
    assign mask     = 8'hFF >> (3'd7 - len_q);
    assign match    = (state == RUN) && x_valid && !abort
                      && (fill >= {1'b0, len_q})
                      && (((window ^ pat_q) & mask) == 8'h00);
    assign cnt_inc  = (match_cnt == 8'hFF) ? 8'hFF : match_cnt + 8'd1;
    assign fill_inc = (fill == 4'd8) ? 4'd8 : fill + 4'd1;

    assign y         = match;
    assign cfg_ready = (state == IDLE);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pat_q      <= 8'h00;
            len_q      <= 3'd0;
            ovl_q      <= 1'b0;
            tgt_q      <= 8'h00;
            cfg_loaded <= 1'b0;
            hist       <= 7'd0;
            fill       <= 4'd0;
            match_cnt  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        pat_q      <= cfg_pattern;
                        len_q      <= cfg_len;
                        ovl_q      <= cfg_overlap;
                        tgt_q      <= cfg_target;
                        cfg_loaded <= 1'b1;
                    end
                    // A config offered alongside start counts as loaded for that start.
                    if (start && (cfg_loaded || cfg_valid)) begin
                        state     <= RUN;
                        hist      <= 7'd0;
                        fill      <= 4'd0;
                        match_cnt <= 8'h00;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (x_valid) begin
                        if (match) begin
                            match_cnt <= cnt_inc;
                            if (ovl_q) begin
                                hist <= window[6:0];
                                fill <= fill_inc;
                            end else begin
                                hist <= 7'd0;
                                fill <= 4'd0;
                            end
                            if ((tgt_q != 8'h00) && (cnt_inc == tgt_q)) begin
                                state <= DONE;
                            end
                        end else begin
                            hist <= window[6:0];
                            fill <= fill_inc;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: inputs driven on negedge, outputs checked
// #1 later, against hand-computed expectations.
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_pattern;
    logic [2:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_target;
    logic       start;
    logic       abort;
    logic       x;
    logic       x_valid;
    logic       y;
    logic       busy;
    logic       done;
    logic [7:0] match_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    seq_det_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .x           (x),
        .x_valid     (x_valid),
        .y           (y),
        .busy        (busy),
        .done        (done),
        .match_cnt   (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer config together with start; run begins on the same edge.
    task automatic cfg_start(input logic [7:0] pat, input logic [2:0] len,
                             input logic ovl, input logic [7:0] tgt);
        @(negedge clk);
        cfg_valid   = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_target  = tgt;
        start       = 1'b1;
        #1 chk("cfg_ready_idle", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b0;
        #1 chk("busy_after_start", busy, 1);
    endtask

    // One valid bit followed by one idle (x_valid=0) cycle.
    task automatic bit_in(input string tag, input logic b, input logic ab, input logic exp_y);
        @(negedge clk);
        x       = b;
        x_valid = 1'b1;
        abort   = ab;
        #1 chk(tag, y, exp_y);
        @(negedge clk);
        x_valid = 1'b0;
        abort   = 1'b0;
    endtask

    task automatic stop_run();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        logic [6:0] seq;
        seq = 7'b1010101;
        rst = 1'b0; cfg_valid = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
        cfg_target = 0; start = 0; abort = 0; x = 0; x_valid = 0;
        #12;
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", match_cnt, 0);
        rst = 1'b1;

        // start without any config is ignored
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1 chk("start_no_cfg", busy, 0);

        // overlapping 1010 over 1,0,1,0,1,0,1
        cfg_start(8'h0A, 3'd3, 1'b1, 8'd0);
        for (int i = 0; i < 7; i++)
            bit_in("ovl_y", seq[6-i], 1'b0, (i == 3) || (i == 5));
        #1 chk("ovl_cnt", match_cnt, 2);
        chk("ovl_busy", busy, 1);
        stop_run();
        #1 chk("ovl_cnt_hold_idle", match_cnt, 2);

        // non-overlapping
        cfg_start(8'h0A, 3'd3, 1'b0, 8'd0);
        for (int i = 0; i < 7; i++)
            bit_in("novl_y", seq[6-i], 1'b0, i == 3);
        #1 chk("novl_cnt", match_cnt, 1);
        stop_run();

        // L=2 pattern 11, target 2
        cfg_start(8'h03, 3'd1, 1'b1, 8'd2);
        bit_in("t2_y1", 1'b1, 1'b0, 1'b0);
        bit_in("t2_y2", 1'b1, 1'b0, 1'b1);
        bit_in("t2_y3", 1'b1, 1'b0, 1'b1);
        #1 chk("t2_done", done, 1);
        chk("t2_busy", busy, 0);
        bit_in("t2_y4", 1'b1, 1'b0, 1'b0);
        #1 chk("t2_done_end", done, 0);
        chk("t2_cnt", match_cnt, 2);
        chk("t2_idle_ready", cfg_ready, 1);

        // abort on the completing bit
        cfg_start(8'h0A, 3'd3, 1'b1, 8'd0);
        bit_in("ab_y1", 1'b1, 1'b0, 1'b0);
        bit_in("ab_y2", 1'b0, 1'b0, 1'b0);
        bit_in("ab_y3", 1'b1, 1'b0, 1'b0);
        bit_in("ab_y4", 1'b0, 1'b1, 1'b0);
        #1 chk("ab_busy", busy, 0);
        chk("ab_cnt", match_cnt, 0);
        chk("ab_done", done, 0);
        repeat (3) begin
            @(negedge clk);
            #1 chk("ab_no_done", done, 0);
        end

        // cfg offered during RUN is refused; original 1010 still detected
        cfg_start(8'h0A, 3'd3, 1'b1, 8'd0);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_pattern = 8'h0F; cfg_len = 3'd3; cfg_target = 8'd1;
        #1 chk("run_cfg_ready", cfg_ready, 0);
        bit_in("rc_y1", 1'b1, 1'b0, 1'b0);
        bit_in("rc_y2", 1'b0, 1'b0, 1'b0);
        bit_in("rc_y3", 1'b1, 1'b0, 1'b0);
        bit_in("rc_y4", 1'b0, 1'b0, 1'b1);
        #1 chk("rc_busy", busy, 1);
        chk("rc_cnt", match_cnt, 1);
        cfg_valid = 1'b0;
        stop_run();

        // reuse loaded config without reconfiguring
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1 chk("reuse_busy", busy, 1);
        bit_in("ru_y1", 1'b1, 1'b0, 1'b0);
        bit_in("ru_y2", 1'b0, 1'b0, 1'b0);
        bit_in("ru_y3", 1'b1, 1'b0, 1'b0);

        // async reset mid-run
        @(negedge clk);
        x = 1'b0; x_valid = 1'b1;
        #2 rst = 1'b0;
        #1 chk("mr_y", y, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_ready", cfg_ready, 1);
        chk("mr_cnt", match_cnt, 0);
        x_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1 chk("mr_start_ignored", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
